// File: rtl/uart_rx_controller.sv
// Receive-side controller: FWFT character FIFO with ready/valid host port,
// sticky overflow flag and optional line-idle timeout pulse.
// Optional timer built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_controller #(
  parameter int DATA_BITS   = 8,
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     char_i,
  input  logic                     char_valid_i,
  input  logic                     clear_i,
  output logic [DATA_BITS-1:0]     data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     timeout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;
  // A full FIFO still accepts a character when the head leaves in the same cycle.
  assign push    = char_valid_i && (!full || pop);
  assign drop    = char_valid_i && full && !pop;

  assign count_o = wr_ptr - rd_ptr;
  assign data_o  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !clear_i && push) begin
      mem[wr_ptr[AW-1:0]] <= char_i;
    end
  end

  // Pointers and sticky overflow; clear wins over push/pop and drop.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  typedef enum logic {
    T_IDLE,
    T_ARMED
  } tstate_t;

  localparam logic [15:0] LAST_CNT = 16'(IDLE_CYCLES - 1);
  localparam logic [AW:0] ONE_ENT  = (AW+1)'(1);

  tstate_t     tstate;
  logic [15:0] idle_cnt;

  // Idle timer: restarts on every push, fires once per idle period while data waits.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      tstate    <= T_IDLE;
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (tstate)
        T_IDLE: begin
          if (push) begin
            tstate   <= T_ARMED;
            idle_cnt <= '0;
          end
        end
        T_ARMED: begin
          if (push) begin
            idle_cnt <= '0;
          end else if (pop && (count_o == ONE_ENT)) begin
            // Host drained everything: nothing left to report.
            tstate <= T_IDLE;
          end else if ((idle_cnt == LAST_CNT) && !empty) begin
            timeout_o <= 1'b1;
            tstate    <= T_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end
`else
  // No timer in this build; IDLE_CYCLES folds away to a constant zero.
  assign timeout_o = 1'b0 & (IDLE_CYCLES == 0);
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: FIFO, overflow, clear, timer, reset.
// Expected timeout behaviour follows whether UART_RX_CTRL_TIMEOUT_EN is defined.
module tb_uart_rx_controller;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_i;
  logic       char_valid_i;
  logic       clear_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       timeout_o;

  int checks = 0;
  int fails  = 0;

  uart_rx_controller #(
    .DATA_BITS(8),
    .DEPTH(4),
    .IDLE_CYCLES(640)
  ) dut (
    .clk(clk),
    .rst(rst),
    .char_i(char_i),
    .char_valid_i(char_valid_i),
    .clear_i(clear_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Advance through one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    char_i       = v;
    char_valid_i = 1'b1;
    step();
    char_valid_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"}, 32'(data_o), 32'(exp));
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  // Count timeout pulses over n edges; first holds the edge index of the first pulse.
  task automatic watch(input int n, output int pulses, output int first);
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (timeout_o === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  int np;
  int fp;

  initial begin
    rst          = 1'b1;
    char_i       = '0;
    char_valid_i = 1'b0;
    clear_i      = 1'b0;
    ready_i      = 1'b0;
    step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_tmo", 32'(timeout_o), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single character through the FIFO.
    push(8'hA5);
    chk("s1_valid", 32'(valid_o), 32'd1);
    chk("s1_data", 32'(data_o), 32'hA5);
    chk("s1_count", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("s1_pop_valid", 32'(valid_o), 32'd0);
    chk("s1_pop_count", 32'(count_o), 32'd0);

    // Fill past capacity: fifth character is dropped.
    for (int i = 1; i <= 5; i++) begin
      push(8'(i));
      if (i == 4) begin
        chk("s2_full_count", 32'(count_o), 32'd4);
        chk("s2_full_ovf", 32'(overflow_o), 32'd0);
      end
      idle(159);
    end
    chk("s2_ovf", 32'(overflow_o), 32'd1);
    chk("s2_count", 32'(count_o), 32'd4);
    pop_chk("s2_p1", 8'h01);
    pop_chk("s2_p2", 8'h02);
    pop_chk("s2_p3", 8'h03);
    pop_chk("s2_p4", 8'h04);
    chk("s2_empty", 32'(valid_o), 32'd0);
    chk("s2_ovf_sticky", 32'(overflow_o), 32'd1);
    // Clear with a character arriving the same cycle: char is discarded silently.
    char_i       = 8'h33;
    char_valid_i = 1'b1;
    clear_i      = 1'b1;
    step();
    char_valid_i = 1'b0;
    clear_i      = 1'b0;
    chk("s2_clr_ovf", 32'(overflow_o), 32'd0);
    chk("s2_clr_count", 32'(count_o), 32'd0);
    chk("s2_clr_valid", 32'(valid_o), 32'd0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      idle(159);
    end
    char_i       = 8'h55;
    char_valid_i = 1'b1;
    ready_i      = 1'b1;
    step();
    char_valid_i = 1'b0;
    ready_i      = 1'b0;
    chk("s3_ovf", 32'(overflow_o), 32'd0);
    chk("s3_count", 32'(count_o), 32'd4);
    pop_chk("s3_p1", 8'h02);
    pop_chk("s3_p2", 8'h03);
    pop_chk("s3_p3", 8'h04);
    pop_chk("s3_p4", 8'h55);
    chk("s3_empty", 32'(count_o), 32'd0);
    do_clear();

    // Idle timeout with an undrained FIFO, then re-arm on a new push.
    push(8'h10);
    watch(2700, np, fp);
    chk("s4_pulses", 32'(np), TMO ? 32'd1 : 32'd0);
    chk("s4_when", 32'(fp), TMO ? 32'd640 : 32'd0);
    push(8'h11);
    watch(700, np, fp);
    chk("s4_rearm_pulses", 32'(np), TMO ? 32'd1 : 32'd0);
    chk("s4_rearm_when", 32'(fp), TMO ? 32'd640 : 32'd0);
    chk("s4_count", 32'(count_o), 32'd2);
    do_clear();

    // Draining the FIFO disarms the timer.
    push(8'h20);
    idle(9);
    pop_chk("s5_pop", 8'h20);
    watch(1000, np, fp);
    chk("s5_pulses", 32'(np), 32'd0);
    chk("s5_empty", 32'(valid_o), 32'd0);

    // Reset mid-operation with three entries and the timer armed.
    push(8'hB1);
    idle(159);
    push(8'hB2);
    idle(159);
    push(8'hB3);
    idle(5);
    chk("s6_pre_count", 32'(count_o), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_valid", 32'(valid_o), 32'd0);
    chk("s6_count", 32'(count_o), 32'd0);
    chk("s6_ovf", 32'(overflow_o), 32'd0);
    chk("s6_tmo", 32'(timeout_o), 32'd0);
    watch(700, np, fp);
    chk("s6_no_pulse", 32'(np), 32'd0);
    push(8'h7E);
    chk("s6_push_valid", 32'(valid_o), 32'd1);
    chk("s6_push_data", 32'(data_o), 32'h7E);
    chk("s6_push_count", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("s6_pop_valid", 32'(valid_o), 32'd0);
    chk("s6_pop_count", 32'(count_o), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side controller for the UART lite core. It sits downstream of character recovery and takes that block's one-cycle `char`/`valid` pulses. It buffers characters in a small first-word-fall-through FIFO and hands them to the host over a ready/valid handshake. It also reports overflow (sticky) and an optional line-idle timeout event, so software can drain partial messages without polling.

## Interface
- `DATA_BITS`, 8, character width; must equal character recovery's `DATA_BITS`.
- `DEPTH`, 4, FIFO entries; power of two, 2..64.
- `IDLE_CYCLES`, 640, clk cycles of silence before a timeout fires (4 character times at 16x oversampling); 1..65535.

- `clk`, in, 1, clock.
- `rst`, in, 1, reset, synchronous, active-high.
- `char_i`, in, DATA_BITS, received character; qualified by `char_valid_i`.
- `char_valid_i`, in, 1, one-cycle pulse per received character; pulses are at least 160 cycles apart.
- `clear_i`, in, 1, flushes the FIFO, clears `overflow_o`, disarms the timer.
- `data_o`, out, DATA_BITS, FIFO head character.
- `valid_o`, out, 1, FIFO non-empty.
- `ready_i`, in, 1, host accepts the head when `valid_o && ready_i`.
- `count_o`, out, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- `overflow_o`, out, 1, sticky; set when a character is dropped.
- `timeout_o`, out, 1, one-cycle idle-timeout pulse.

## Operation
- FIFO: circular buffer with wr/rd pointers one bit wider than the index. Full is signalled when the MSBs differ and the index bits are equal. Empty is signalled when the pointers are equal. Pointers wrap modulo 2·DEPTH.
- Push occurs on `char_valid_i` when either:
  - the FIFO is not full, or
  - the FIFO is full and a pop happens the same cycle.
- Pop occurs on `valid_o && ready_i`.
- Simultaneous push and pop: both take effect and `count_o` is unchanged. This applies when the FIFO is full. When the FIFO is empty, push only occurs (`valid_o` is 0).
- Drop: `char_valid_i` with the FIFO full and no pop. The character is discarded, `overflow_o` is set on the next edge, and FIFO contents are untouched.
- `clear_i` has priority over push, pop and timer. It sets both pointers to 0 and `overflow_o` to 0, and puts the timer in IDLE. A char arriving in the same cycle is discarded and does not set `overflow_o`.
- `data_o` equals `mem[rd_ptr]`. Its value is don't-care when `valid_o` is 0; the bench must not check it then.
- Timer state machine (with the macro defined):
  - IDLE: on a push, go to ARMED and load the counter with 0.
  - ARMED, push: reload the counter with 0 and stay in ARMED.
  - ARMED, FIFO becomes empty (pop of the last entry, no push): go to IDLE with no pulse.
  - ARMED, counter == IDLE_CYCLES-1 and FIFO non-empty: pulse `timeout_o` and go to IDLE.
  - ARMED, otherwise: increment the counter.
  - The counter is 16 bits and never wraps, because it stops at IDLE_CYCLES-1.
- Re-arm occurs only on a new push; an undrained FIFO yields exactly one pulse per idle period.

## Timing
- Reset values: `valid_o`=0, `count_o`=0, `overflow_o`=0, `timeout_o`=0, pointers=0, timer=IDLE, counter=0. `data_o` is undefined, and memory is not reset.
- Latency from `char_valid_i` at edge N:
  - `valid_o`=1 and `data_o`=char after edge N (visible in cycle N+1).
  - `count_o` is updated at the same edge.
- Pop latency: a handshake at edge N advances the head, and the new `data_o`/`valid_o` are visible after edge N.
- `overflow_o` rises at the edge where the drop occurs.
- `timeout_o` is high for exactly the cycle after the edge where the counter reaches IDLE_CYCLES-1. With no intervening activity, this is IDLE_CYCLES cycles after the last push.
- `rst` mid-operation: all state returns to reset values at the next edge. `rst` has priority over `clear_i`.

## Configuration
- `UART_RX_CTRL_TIMEOUT_EN` defined: the timer state machine is built as described.
- `UART_RX_CTRL_TIMEOUT_EN` undefined: no timer or counter logic, and `timeout_o` is tied to 0. `IDLE_CYCLES` is accepted but unused. All other behaviour is identical.

## Test plan
- Reset, then single push of 0xA5 with `ready_i`=0: `valid_o`=1, `data_o`=0xA5, `count_o`=1 one cycle later. Set `ready_i`=1: `valid_o`=0, `count_o`=0 after the next edge.
- DEPTH=4: push 0x01..0x05 at 160-cycle spacing, `ready_i`=0. Expect `count_o`=4, `overflow_o`=1 after the 5th push, then pops return 0x01,0x02,0x03,0x04. `clear_i` pulse: `overflow_o`=0, `count_o`=0.
- FIFO full with pop and push in the same cycle (push 0x55): no overflow, `count_o` stays 4, 0x55 is read last.
- Macro defined, IDLE_CYCLES=640: push 0x10, hold `ready_i`=0. `timeout_o` pulses once, 640 cycles after the push, and stays 0 for the next 2000 cycles. A second push re-arms and gives a second pulse 640 cycles later.
- Macro defined: push 0x20, pop it 10 cycles later: no `timeout_o` pulse within 1000 cycles. Macro undefined: the earlier 0x10 scenario gives `timeout_o`=0 throughout.
- Assert `rst` with `count_o`=3 and the timer ARMED: all outputs return to reset values the next cycle, and a subsequent push of 0x7E behaves as the first scenario.
